// File: rtl/pipeline_hazard_ctrl.sv
// Pipeline hazard sequencer: decides stall, bubble, flush and PC redirect each cycle
// for load-use hazards, taken branches and multi-cycle data-memory accesses.
module pipeline_hazard_ctrl #(
    parameter int unsigned BIN_DIG      = 32,
    parameter int unsigned DMEM_TIMEOUT = 64,
    parameter int unsigned CNT_W        = 16
) (
    input  logic               CLK,
    input  logic               RST,
    input  logic               dec_valid,
    input  logic [4:0]         dec_rs1,
    input  logic [4:0]         dec_rs2,
    input  logic               dec_use_rs1,
    input  logic               dec_use_rs2,
    input  logic               ex_valid,
    input  logic               ex_is_load,
    input  logic [4:0]         ex_rd,
    input  logic               ex_branch_taken,
    input  logic [BIN_DIG-1:0] ex_branch_target,
    input  logic               dmem_req,
    input  logic               dmem_ack,
    output logic               stall_fetch,
    output logic               stall_decode,
    output logic               stall_exec,
    output logic               bubble_exec,
    output logic               flush_decode,
    output logic               redirect_valid,
    output logic [BIN_DIG-1:0] redirect_pc,
    output logic               err_timeout,
    output logic [CNT_W-1:0]   stall_cnt
);

    localparam int unsigned TO_W = $clog2(DMEM_TIMEOUT + 1);

    typedef enum logic [1:0] {
        StRun      = 2'd0,
        StDmemWait = 2'd1,
        StFlush    = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [BIN_DIG-1:0] rpc_q, rpc_d;
    logic               err_q, err_d;
    logic [CNT_W-1:0]   stall_cnt_q, stall_cnt_d;

    logic mem_busy, br, lu;
    logic sf, sd, se, bx, fd, rv;

    assign mem_busy = ex_valid & dmem_req & ~dmem_ack;
    assign br       = ex_valid & ex_branch_taken;
    assign lu       = ex_valid & ex_is_load & dec_valid & (ex_rd != 5'd0) &
                      ((dec_use_rs1 & (dec_rs1 == ex_rd)) | (dec_use_rs2 & (dec_rs2 == ex_rd)));

    always_comb begin
        state_d  = state_q;
        to_cnt_d = to_cnt_q;
        rpc_d    = rpc_q;
        err_d    = err_q;
        sf = 1'b0;
        sd = 1'b0;
        se = 1'b0;
        bx = 1'b0;
        fd = 1'b0;
        rv = 1'b0;
        case (state_q)
            StRun: begin
                // A stalled memory access re-presents any branch or hazard later.
                if (mem_busy) begin
                    sf       = 1'b1;
                    sd       = 1'b1;
                    se       = 1'b1;
                    state_d  = StDmemWait;
                    to_cnt_d = TO_W'(1);
                end else if (br) begin
                    fd      = 1'b1;
                    bx      = 1'b1;
                    rpc_d   = ex_branch_target;
                    state_d = StFlush;
                end else if (lu) begin
                    sf = 1'b1;
                    sd = 1'b1;
                    bx = 1'b1;
                end
            end
            StDmemWait: begin
                sf = 1'b1;
                sd = 1'b1;
                se = 1'b1;
                if (dmem_ack) begin
                    state_d  = StRun;
                    to_cnt_d = '0;
                end else if (to_cnt_q == TO_W'(DMEM_TIMEOUT)) begin
                    err_d    = 1'b1;
                    state_d  = StRun;
                    to_cnt_d = '0;
                end else begin
                    to_cnt_d = to_cnt_q + TO_W'(1);
                end
            end
            StFlush: begin
                rv      = 1'b1;
                fd      = 1'b1;
                bx      = 1'b1;
                state_d = StRun;
            end
            default: begin
                state_d  = StRun;
                to_cnt_d = '0;
            end
        endcase
    end

    assign stall_cnt_d = (sf && (stall_cnt_q != {CNT_W{1'b1}})) ? stall_cnt_q + CNT_W'(1)
                                                                 : stall_cnt_q;

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q     <= StRun;
            to_cnt_q    <= '0;
            rpc_q       <= '0;
            err_q       <= 1'b0;
            stall_cnt_q <= '0;
        end else begin
            state_q     <= state_d;
            to_cnt_q    <= to_cnt_d;
            rpc_q       <= rpc_d;
            err_q       <= err_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    // Combinational controls are forced low for the whole time reset is held.
    assign stall_fetch    = sf & RST;
    assign stall_decode   = sd & RST;
    assign stall_exec     = se & RST;
    assign bubble_exec    = bx & RST;
    assign flush_decode   = fd & RST;
    assign redirect_valid = rv & RST;
    assign redirect_pc    = rpc_q;
    assign err_timeout    = err_q;
    assign stall_cnt      = stall_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Scoreboard bench for pipeline_hazard_ctrl: hand-written expected controls are queued
// as stimulus is driven and compared on the following falling edge.
module tb_pipeline_hazard_ctrl;

    logic        CLK;
    logic        RST;
    logic        dec_valid;
    logic [4:0]  dec_rs1;
    logic [4:0]  dec_rs2;
    logic        dec_use_rs1;
    logic        dec_use_rs2;
    logic        ex_valid;
    logic        ex_is_load;
    logic [4:0]  ex_rd;
    logic        ex_branch_taken;
    logic [31:0] ex_branch_target;
    logic        dmem_req;
    logic        dmem_ack;
    logic        stall_fetch;
    logic        stall_decode;
    logic        stall_exec;
    logic        bubble_exec;
    logic        flush_decode;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        err_timeout;
    logic [3:0]  stall_cnt;

    pipeline_hazard_ctrl #(
        .BIN_DIG      (32),
        .DMEM_TIMEOUT (4),
        .CNT_W        (4)
    ) dut (
        .CLK              (CLK),
        .RST              (RST),
        .dec_valid        (dec_valid),
        .dec_rs1          (dec_rs1),
        .dec_rs2          (dec_rs2),
        .dec_use_rs1      (dec_use_rs1),
        .dec_use_rs2      (dec_use_rs2),
        .ex_valid         (ex_valid),
        .ex_is_load       (ex_is_load),
        .ex_rd            (ex_rd),
        .ex_branch_taken  (ex_branch_taken),
        .ex_branch_target (ex_branch_target),
        .dmem_req         (dmem_req),
        .dmem_ack         (dmem_ack),
        .stall_fetch      (stall_fetch),
        .stall_decode     (stall_decode),
        .stall_exec       (stall_exec),
        .bubble_exec      (bubble_exec),
        .flush_decode     (flush_decode),
        .redirect_valid   (redirect_valid),
        .redirect_pc      (redirect_pc),
        .err_timeout      (err_timeout),
        .stall_cnt        (stall_cnt)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // ctl bit order: {stall_fetch, stall_decode, stall_exec, bubble_exec, flush_decode, redirect_valid}
    typedef struct {
        logic [5:0]  ctl;
        logic [31:0] rpc;
        logic        err;
        logic [3:0]  cnt;
    } exp_t;

    exp_t        sb[$];
    exp_t        e_mon;
    int          n_chk  = 0;
    int          n_pass = 0;
    int          n_cyc  = 0;
    logic [31:0] exp_rpc = '0;
    logic        exp_err = 1'b0;
    logic [3:0]  exp_cnt = '0;

    wire [5:0] ctl_obs = {stall_fetch, stall_decode, stall_exec,
                          bubble_exec, flush_decode, redirect_valid};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, ".ctl"}, 32'(ctl_obs), 32'd0);
        chk({tag, ".rpc"}, redirect_pc, 32'd0);
        chk({tag, ".err"}, 32'(err_timeout), 32'd0);
        chk({tag, ".cnt"}, 32'(stall_cnt), 32'd0);
    endtask

    task automatic idle();
        dec_valid = 0; dec_rs1 = 0; dec_rs2 = 0; dec_use_rs1 = 0; dec_use_rs2 = 0;
        ex_valid = 0; ex_is_load = 0; ex_rd = 0; ex_branch_taken = 0;
        ex_branch_target = '0; dmem_req = 0; dmem_ack = 0;
    endtask

    task automatic nxt();
        @(posedge CLK);
        #1;
        idle();
    endtask

    // Registered outputs seen this cycle reflect earlier edges; stall_cnt is then advanced.
    task automatic push(input logic [5:0] ctl);
        exp_t e;
        e.ctl = ctl;
        e.rpc = exp_rpc;
        e.err = exp_err;
        e.cnt = exp_cnt;
        sb.push_back(e);
        if (ctl[5] && exp_cnt != 4'hF) exp_cnt = exp_cnt + 4'd1;
    endtask

    task automatic set_lu(input logic [4:0] rd, input logic [4:0] rs1);
        ex_valid = 1; ex_is_load = 1; ex_rd = rd;
        dec_valid = 1; dec_rs1 = rs1; dec_use_rs1 = 1;
    endtask

    always @(negedge CLK) begin
        if (sb.size() > 0) begin
            e_mon = sb.pop_front();
            n_cyc++;
            chk($sformatf("c%0d.ctl", n_cyc), 32'(ctl_obs), 32'(e_mon.ctl));
            chk($sformatf("c%0d.rpc", n_cyc), redirect_pc, e_mon.rpc);
            chk($sformatf("c%0d.err", n_cyc), 32'(err_timeout), 32'(e_mon.err));
            chk($sformatf("c%0d.cnt", n_cyc), 32'(stall_cnt), 32'(e_mon.cnt));
        end
    end

    initial begin
        RST = 1'b0;
        idle();
        #3;
        chk_zero("rst_init");
        // Controls must stay low under reset even with every hazard input active.
        ex_valid = 1; ex_branch_taken = 1; dmem_req = 1; ex_branch_target = 32'h55;
        #1;
        chk("rst_gate", 32'(ctl_obs), 32'd0);
        idle();
        #8;
        RST = 1'b1;

        nxt(); push(6'b000000);
        // Load-use on rs1, then idle.
        nxt(); set_lu(5'd5, 5'd5); push(6'b110100);
        nxt(); push(6'b000000);
        // x0 destination never hazards.
        nxt(); set_lu(5'd0, 5'd0); push(6'b000000);
        // Hazard through rs2 only.
        nxt(); ex_valid = 1; ex_is_load = 1; ex_rd = 7; dec_valid = 1;
        dec_rs2 = 7; dec_use_rs2 = 1; dec_rs1 = 3; push(6'b110100);
        // Matching rs2 but not read.
        nxt(); ex_valid = 1; ex_is_load = 1; ex_rd = 7; dec_valid = 1; dec_rs2 = 7;
        push(6'b000000);
        // Decode slot empty.
        nxt(); set_lu(5'd9, 5'd9); dec_valid = 0; push(6'b000000);
        // Non-load producer.
        nxt(); set_lu(5'd9, 5'd9); ex_is_load = 0; push(6'b000000);

        // Taken branch with a simultaneous load-use that must be ignored.
        nxt(); set_lu(5'd4, 5'd4); ex_branch_taken = 1; ex_branch_target = 32'h100;
        push(6'b000110); exp_rpc = 32'h100;
        nxt(); ex_valid = 1; ex_branch_taken = 1; ex_branch_target = 32'h200;
        push(6'b000111);
        nxt(); push(6'b000000);
        nxt(); ex_branch_taken = 1; ex_branch_target = 32'h300; push(6'b000000);

        // DMEM wait, ack three cycles after the request.
        nxt(); ex_valid = 1; dmem_req = 1; push(6'b111000);
        nxt(); ex_valid = 1; dmem_req = 1; push(6'b111000);
        nxt(); ex_valid = 1; dmem_req = 1; push(6'b111000);
        nxt(); ex_valid = 1; dmem_req = 1; dmem_ack = 1; push(6'b111000);
        nxt(); push(6'b000000);
        // Stray ack, and same-cycle ack, in RUN.
        nxt(); ex_valid = 1; dmem_ack = 1; push(6'b000000);
        nxt(); ex_valid = 1; dmem_req = 1; dmem_ack = 1; push(6'b000000);

        // Timeout: five stalled cycles, then err sticks.
        for (int i = 0; i < 5; i++) begin
            nxt(); ex_valid = 1; dmem_req = 1; push(6'b111000);
        end
        exp_err = 1'b1;
        nxt(); push(6'b000000);
        nxt(); push(6'b000000);

        // Priority: memory stall wins, branch replays after ack.
        nxt(); set_lu(5'd5, 5'd5); dmem_req = 1; ex_branch_taken = 1;
        ex_branch_target = 32'h300; push(6'b111000);
        nxt(); set_lu(5'd5, 5'd5); dmem_req = 1; ex_branch_taken = 1;
        ex_branch_target = 32'h300; push(6'b111000);
        nxt(); ex_valid = 1; dmem_req = 1; dmem_ack = 1; ex_branch_taken = 1;
        ex_branch_target = 32'h300; push(6'b111000);
        nxt(); ex_valid = 1; ex_branch_taken = 1; ex_branch_target = 32'h300;
        push(6'b000110); exp_rpc = 32'h300;
        nxt(); push(6'b000111);
        nxt(); push(6'b000000);

        // Push stall_cnt into saturation.
        for (int i = 0; i < 3; i++) begin
            nxt(); set_lu(5'd6, 5'd6); push(6'b110100);
        end
        nxt(); push(6'b000000);

        // Async reset in the middle of FLUSH.
        nxt(); ex_valid = 1; ex_branch_taken = 1; ex_branch_target = 32'h400;
        push(6'b000110); exp_rpc = 32'h400;
        @(posedge CLK);
        #1;
        idle();
        #1;
        chk("flush_rv", 32'(redirect_valid), 32'd1);
        chk("flush_rpc", redirect_pc, 32'h400);
        RST = 1'b0;
        #1;
        chk_zero("rst_flush");
        @(negedge CLK);
        #2;
        RST = 1'b1;
        exp_cnt = '0; exp_rpc = '0; exp_err = 1'b0;
        nxt(); push(6'b000000);

        // Async reset in the middle of DMEM_WAIT.
        nxt(); ex_valid = 1; dmem_req = 1; push(6'b111000);
        nxt(); ex_valid = 1; dmem_req = 1; push(6'b111000);
        @(negedge CLK);
        #1;
        RST = 1'b0;
        #1;
        chk_zero("rst_dmem");
        idle();
        #2;
        RST = 1'b1;
        exp_cnt = '0; exp_rpc = '0; exp_err = 1'b0;
        nxt(); push(6'b000000);
        nxt(); push(6'b000000);

        @(negedge CLK);
        #1;
        chk("sb_drain", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
- Central sequencer for the fetch -> decode -> exec/dmem -> writeback pipeline.
- Watches the decode and exec/dmem stages and decides, each cycle, to stall, bubble, flush or redirect.
- Covers three cases: load-use hazards, taken branches/jumps, and multi-cycle data-memory accesses.
- Drives the hold and kill controls of the fetch-to-decode and decode-to-exec pipeline registers, plus the PC redirect into fetch.

Parameters:
- BIN_DIG, 32, datapath and PC width.
- DMEM_TIMEOUT, 64, maximum number of cycles spent in DMEM_WAIT before aborting.
- CNT_W, 16, width of the stall performance counter.

Ports:
- CLK  input  1  clock; all state updates on the rising edge.
- RST  input  1  reset; asynchronous, active-low. RST=0 forces reset immediately, independent of CLK.
- dec_valid  input  1  decode stage holds a valid instruction.
- dec_rs1  input  5  decode source register 1.
- dec_rs2  input  5  decode source register 2.
- dec_use_rs1  input  1  decode instruction reads rs1.
- dec_use_rs2  input  1  decode instruction reads rs2.
- ex_valid  input  1  exec/dmem stage holds a valid instruction.
- ex_is_load  input  1  exec/dmem instruction is a load.
- ex_rd  input  5  exec/dmem destination register.
- ex_branch_taken  input  1  exec resolved a taken branch or jump this cycle.
- ex_branch_target  input  BIN_DIG  resolved target PC.
- dmem_req  input  1  exec/dmem stage issues a memory access this cycle.
- dmem_ack  input  1  memory completes the access this cycle.
- stall_fetch  output  1  hold the PC and the fetch-to-decode register.
- stall_decode  output  1  hold the decode-stage contents.
- stall_exec  output  1  hold the exec/dmem stage; writeback receives nothing.
- bubble_exec  output  1  load a NOP (all zero) into the decode-to-exec register.
- flush_decode  output  1  load zero into the fetch-to-decode register.
- redirect_valid  output  1  fetch loads redirect_pc at the next edge.
- redirect_pc  output  BIN_DIG  redirect target.
- err_timeout  output  1  sticky flag: a DMEM_WAIT timeout has occurred.
- stall_cnt  output  CNT_W  saturating count of cycles with stall_fetch=1.

Behaviour:
- States, 2-bit encoding: RUN=0, DMEM_WAIT=1, FLUSH=2. Encoding 3 is illegal and recovers to RUN on the next edge.
- Outputs are combinational from the current state and inputs. Exceptions, which are registered: redirect_pc, err_timeout, stall_cnt, timeout counter.
- Reset (RST=0, asynchronous):
  - state=RUN; redirect_pc=0; err_timeout=0; stall_cnt=0; timeout counter=0.
  - All combinational outputs evaluate to 0 while RST=0.
  - Reset in any state aborts that state with no residual redirect or stall.
- Signals evaluated in RUN, priority high to low:
  1. mem_busy = ex_valid & dmem_req & !dmem_ack.
  2. br = ex_valid & ex_branch_taken.
  3. lu = ex_valid & ex_is_load & dec_valid & ex_rd!=0 & ((dec_use_rs1 & dec_rs1==ex_rd) | (dec_use_rs2 & dec_rs2==ex_rd)).
- RUN with mem_busy:
  - Assert stall_fetch, stall_decode, stall_exec.
  - Next state DMEM_WAIT; timeout counter <= 1.
  - br and lu are ignored this cycle; the stalled instruction re-presents them later.
- RUN with br (no mem_busy):
  - Assert flush_decode and bubble_exec this cycle.
  - redirect_pc <= ex_branch_target; next state FLUSH.
  - lu is ignored: the younger instruction is killed.
- RUN with lu only:
  - Assert stall_fetch, stall_decode, bubble_exec for this single cycle; remain in RUN.
- RUN with none: all controls 0.
- DMEM_WAIT:
  - stall_fetch, stall_decode, stall_exec = 1.
  - On dmem_ack=1: that cycle still stalls; next state RUN; counter cleared.
  - Else if counter==DMEM_TIMEOUT: err_timeout <= 1; next state RUN; counter cleared. Exec is released and the access is dropped.
  - Else counter increments by 1.
- FLUSH (exactly one cycle):
  - redirect_valid=1, redirect_pc driven; flush_decode=1, bubble_exec=1 to kill the wrong-path fetch.
  - Next state RUN unconditionally. All exec inputs are ignored, since exec holds a bubble.
- dmem_ack in RUN when dmem_req=0 is ignored.
- stall_cnt increments by 1 on every edge where stall_fetch=1 and saturates at 2^CNT_W-1.
- err_timeout clears only on reset.

Test Plan:
- Load-use:
  - Stimulus: ex_is_load=1, ex_rd=5; decode rs1=5 with use_rs1=1.
  - Response: one cycle of stall_fetch=stall_decode=bubble_exec=1; stall_cnt=1; state stays RUN.
  - Repeat with ex_rd=0: no stall.
- Taken branch:
  - Stimulus: ex_branch_taken=1, target 0x0000_0100.
  - Response: cycle N flush_decode=bubble_exec=1; cycle N+1 redirect_valid=1, redirect_pc=0x100; cycle N+2 all controls 0.
- DMEM wait:
  - Stimulus: dmem_req=1, dmem_ack arrives 3 cycles later.
  - Response: 4 cycles of stall_exec=1; returns to RUN; stall_cnt=4; err_timeout=0.
- Timeout:
  - Stimulus: DMEM_TIMEOUT=4, dmem_ack never asserted.
  - Response: err_timeout=1 after the 5th stalled cycle; state RUN; err_timeout remains 1.
- Priority:
  - Stimulus: mem_busy, br and lu all asserted together.
  - Response: DMEM_WAIT entered; no redirect. Once ack is given with br still asserted, the FLUSH sequence follows.
- Async reset:
  - Stimulus: RST=0 in mid-FLUSH and mid-DMEM_WAIT, between clock edges.
  - Response: outputs drop to 0 immediately; state=RUN; counters cleared.
